// File: rtl/bist_resp_checker_pkg.sv
// -----------------------------------------------------------------------------
// bist_resp_checker_pkg
//   Shared definitions for the BIST response checker: FSM state encodings and
//   the default MISR polynomial / seed used by the checker and its MISR step.
//   No ports (package).
// -----------------------------------------------------------------------------
package bist_resp_checker_pkg;

  // FSM state encodings, kept as plain 2-bit constants so the same values can
  // be matched by older tooling and by the top-level test controller.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Default MISR feedback polynomial and start value.
  localparam logic [31:0] DEF_MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_MISR_SEED = 32'hFFFF_FFFF;

endpackage : bist_resp_checker_pkg

// File: rtl/bist_misr.sv
// -----------------------------------------------------------------------------
// bist_misr
//   Combinational single-step MISR next-state function: shift the signature
//   left, fold in the feedback polynomial when the outgoing MSB is set, and
//   XOR in the response word.
// Ports
//   sig_i   in   RESP_W  current signature
//   resp_i  in   RESP_W  response word being compacted
//   sig_o   out  RESP_W  signature after one step
// -----------------------------------------------------------------------------
module bist_misr
  import bist_resp_checker_pkg::*;
#(
  parameter int unsigned         RESP_W    = 32,
  parameter logic [RESP_W-1:0]   MISR_POLY = RESP_W'(DEF_MISR_POLY)
) (
  input  logic [RESP_W-1:0] sig_i,
  input  logic [RESP_W-1:0] resp_i,
  output logic [RESP_W-1:0] sig_o
);

  always_comb begin
    sig_o = {sig_i[RESP_W-2:0], 1'b0}
          ^ (sig_i[RESP_W-1] ? MISR_POLY : '0)
          ^ resp_i;
  end

endmodule : bist_misr

// File: rtl/bist_resp_checker.sv
// -----------------------------------------------------------------------------
// bist_resp_checker
//   Response end of the BIST loop. Compacts PAT_COUNT response beats into a
//   MISR signature, then compares it against GOLDEN_SIG and reports done/pass.
//   Optional feature macro: BIST_TIMEOUT_EN -- aborts a run that stalls for
//   TIMEOUT_CYC cycles without an accepted beat and adds the timeout port.
// Ports
//   clk         in   1       clock, rising edge
//   rst         in   1       synchronous active-low reset
//   start       in   1       begin a run (honoured in IDLE or DONE only)
//   resp_valid  in   1       response beat present
//   resp        in   RESP_W  response word from the CUT
//   resp_ready  out  1       beat accepted this cycle if resp_valid (RUN only)
//   busy        out  1       RUN or CHECK
//   done        out  1       run finished, held until start or reset
//   pass        out  1       final signature matched GOLDEN_SIG (with done)
//   signature   out  RESP_W  current MISR contents
//   pat_cnt     out  clog2(PAT_COUNT+1)  beats accepted this run
//   timeout     out  1       run aborted on a stall (BIST_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module bist_resp_checker
  import bist_resp_checker_pkg::*;
#(
  parameter int unsigned       RESP_W      = 32,
  parameter int unsigned       PAT_COUNT   = 16,
  parameter logic [RESP_W-1:0] MISR_POLY   = RESP_W'(DEF_MISR_POLY),
  parameter logic [RESP_W-1:0] MISR_SEED   = RESP_W'(DEF_MISR_SEED),
  parameter logic [RESP_W-1:0] GOLDEN_SIG  = '0
`ifdef BIST_TIMEOUT_EN
  ,
  parameter int unsigned       TIMEOUT_CYC = 64
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           resp_valid,
  input  logic [RESP_W-1:0]              resp,
  output logic                           resp_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [RESP_W-1:0]              signature,
  output logic [$clog2(PAT_COUNT+1)-1:0] pat_cnt
`ifdef BIST_TIMEOUT_EN
  ,
  output logic                           timeout
`endif
);

  localparam int unsigned     CNT_W    = $clog2(PAT_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAT_COUNT - 1);

  logic [1:0]        state_q, state_d;
  logic [RESP_W-1:0] sig_q,   sig_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              done_q,  done_d;
  logic              pass_q,  pass_d;
  logic [RESP_W-1:0] sig_step;
  logic              accept;

`ifdef BIST_TIMEOUT_EN
  localparam int unsigned       STALL_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;
`endif

  bist_misr #(
    .RESP_W    (RESP_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .sig_i  (sig_q),
    .resp_i (resp),
    .sig_o  (sig_step)
  );

  // Ready is decoded from the registered state only, so it never depends
  // combinationally on resp_valid or start.
  assign resp_ready = (state_q == ST_RUN);
  assign busy       = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign accept     = resp_valid & resp_ready;

  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign pat_cnt   = cnt_q;
`ifdef BIST_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so
    // no path through the case below can leave one unassigned (no latches).
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef BIST_TIMEOUT_EN
    stall_d   = stall_q;
    timeout_d = timeout_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          sig_d   = MISR_SEED;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
`ifdef BIST_TIMEOUT_EN
          stall_d   = '0;
          timeout_d = 1'b0;
`endif
        end
      end

      ST_RUN: begin
        if (accept) begin
          sig_d = sig_step;
          cnt_d = cnt_q + CNT_W'(1);
          // The beat taken while the count shows PAT_COUNT-1 is the last one.
          if (cnt_q == LAST_CNT) begin
            state_d = ST_CHECK;
          end
`ifdef BIST_TIMEOUT_EN
          stall_d = '0;
        end else if (stall_q == STALL_LAST) begin
          // This idle cycle is the TIMEOUT_CYC-th in a row: abort the run.
          state_d   = ST_DONE;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          stall_d = stall_q + STALL_W'(1);
`endif
        end
      end

      ST_CHECK: begin
        pass_d  = (sig_q == GOLDEN_SIG);
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sig_q   <= MISR_SEED;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef BIST_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef BIST_TIMEOUT_EN
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule : bist_resp_checker

// File: tb/tb_bist_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_bist_resp_checker
//   Directed self-checking bench. Two checker instances share one clock:
//   u_small (RESP_W=4, POLY=3, SEED=0, PAT_COUNT=2, GOLDEN=2) for the
//   hand-computed signature cases, and u_dflt (default parameters) for the
//   handshake, reset and start-ignore cases. Build with +define+BIST_TIMEOUT_EN
//   to add the stall-timeout case (TIMEOUT_CYC=8 on u_dflt).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bist_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---- small instance ------------------------------------------------------
  logic       s_rst, s_start, s_valid;
  logic [3:0] s_resp;
  logic       s_ready, s_busy, s_done, s_pass;
  logic [3:0] s_sig;
  logic [1:0] s_cnt;
`ifdef BIST_TIMEOUT_EN
  logic       s_tmo;
`endif

  bist_resp_checker #(
    .RESP_W     (4),
    .PAT_COUNT  (2),
    .MISR_POLY  (4'h3),
    .MISR_SEED  (4'h0),
    .GOLDEN_SIG (4'h2)
  ) u_small (
    .clk        (clk),
    .rst        (s_rst),
    .start      (s_start),
    .resp_valid (s_valid),
    .resp       (s_resp),
    .resp_ready (s_ready),
    .busy       (s_busy),
    .done       (s_done),
    .pass       (s_pass),
    .signature  (s_sig),
    .pat_cnt    (s_cnt)
`ifdef BIST_TIMEOUT_EN
    ,
    .timeout    (s_tmo)
`endif
  );

  // ---- default instance ----------------------------------------------------
  logic        d_rst, d_start, d_valid;
  logic [31:0] d_resp;
  logic        d_ready, d_busy, d_done, d_pass;
  logic [31:0] d_sig;
  logic [4:0]  d_cnt;
`ifdef BIST_TIMEOUT_EN
  logic        d_tmo;
`endif

  bist_resp_checker
`ifdef BIST_TIMEOUT_EN
  #(.TIMEOUT_CYC (8))
`endif
  u_dflt (
    .clk        (clk),
    .rst        (d_rst),
    .start      (d_start),
    .resp_valid (d_valid),
    .resp       (d_resp),
    .resp_ready (d_ready),
    .busy       (d_busy),
    .done       (d_done),
    .pass       (d_pass),
    .signature  (d_sig),
    .pat_cnt    (d_cnt)
`ifdef BIST_TIMEOUT_EN
    ,
    .timeout    (d_tmo)
`endif
  );

  // Independent reference for the default 32-bit MISR step.
  function automatic logic [31:0] misr32(input logic [31:0] s, input logic [31:0] r);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it, inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_beat(input logic [31:0] w);
    d_valid = 1'b1;
    d_resp  = w;
    tick();
    d_valid = 1'b0;
  endtask

  logic [31:0] model;

  initial begin
    s_rst = 1'b0; s_start = 1'b0; s_valid = 1'b0; s_resp = '0;
    d_rst = 1'b0; d_start = 1'b0; d_valid = 1'b0; d_resp = '0;
    tick();
    tick();

    // ---- reset state ----
    check("rst_sig",   d_sig,   32'hFFFF_FFFF);
    check("rst_cnt",   32'(d_cnt), 32'd0);
    check("rst_ready", 32'(d_ready), 32'd0);
    check("rst_busy",  32'(d_busy),  32'd0);
    check("rst_done",  32'(d_done),  32'd0);
    check("rst_pass",  32'(d_pass),  32'd0);
`ifdef BIST_TIMEOUT_EN
    check("rst_tmo",   32'(d_tmo),   32'd0);
`endif
    s_rst = 1'b1;
    d_rst = 1'b1;

    // ---- test 1: A then 5 -> A, 2, pass ----
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("t1_ready",  32'(s_ready), 32'd1);
    check("t1_busy",   32'(s_busy),  32'd1);
    s_valid = 1'b1; s_resp = 4'hA; tick();
    check("t1_sig1",   32'(s_sig),   32'hA);
    check("t1_cnt1",   32'(s_cnt),   32'd1);
    s_resp = 4'h5; tick();
    s_valid = 1'b0;
    check("t1_sig2",   32'(s_sig),   32'h2);
    check("t1_cnt2",   32'(s_cnt),   32'd2);
    check("t1_rdy_lo", 32'(s_ready), 32'd0);
    check("t1_done_n", 32'(s_done),  32'd0);
    tick();
    check("t1_done",   32'(s_done),  32'd1);
    check("t1_pass",   32'(s_pass),  32'd1);
    check("t1_idle",   32'(s_busy),  32'd0);
    tick();
    check("t1_hold",   32'(s_done),  32'd1);
    check("t1_hsig",   32'(s_sig),   32'h2);

    // ---- test 2: restart from DONE, A then 4 -> 3, fail; extra beats refused ----
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("t2_dclr",   32'(s_done),  32'd0);
    check("t2_seed",   32'(s_sig),   32'h0);
    check("t2_cnt0",   32'(s_cnt),   32'd0);
    s_valid = 1'b1; s_resp = 4'hA; tick();
    s_resp = 4'h4; tick();
    check("t2_sig",    32'(s_sig),   32'h3);
    s_resp = 4'hF; tick();   // valid stays high through CHECK and DONE
    tick();
    s_valid = 1'b0;
    check("t2_done",   32'(s_done),  32'd1);
    check("t2_pass",   32'(s_pass),  32'd0);
    check("t2_xsig",   32'(s_sig),   32'h3);
    check("t2_xcnt",   32'(s_cnt),   32'd2);

    // ---- test 3: default, valid held 20 cycles -> exactly 16 beats ----
    d_start = 1'b1; tick(); d_start = 1'b0;
    model = 32'hFFFF_FFFF;
    d_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d_resp = 32'hDEAD_BEEF ^ (32'(i) * 32'h0101_0101);
      if (i < 16) model = misr32(model, d_resp);
      tick();
      if (i == 14) check("t3_rdy15", 32'(d_ready), 32'd1);
      if (i == 15) begin
        check("t3_rdy_lo", 32'(d_ready), 32'd0);
        check("t3_cnt16",  32'(d_cnt),   32'd16);
      end
    end
    d_valid = 1'b0;
    check("t3_cnt",    32'(d_cnt),  32'd16);
    check("t3_sig",    d_sig,       model);
    check("t3_done",   32'(d_done), 32'd1);
    check("t3_pass",   32'(d_pass), 32'(model == 32'h0));

    // ---- test 4: reset after 5 beats, then a fresh run ----
    d_start = 1'b1; tick(); d_start = 1'b0;
    for (int i = 0; i < 5; i++) d_beat(32'h1234_0000 + 32'(i));
    check("t4_cnt5",   32'(d_cnt),  32'd5);
    d_rst = 1'b0; tick(); d_rst = 1'b1;
    check("t4_rsig",   d_sig,        32'hFFFF_FFFF);
    check("t4_rcnt",   32'(d_cnt),   32'd0);
    check("t4_rbusy",  32'(d_busy),  32'd0);
    check("t4_rready", 32'(d_ready), 32'd0);
    check("t4_rdone",  32'(d_done),  32'd0);
    d_start = 1'b1; tick(); d_start = 1'b0;
    check("t4_busy",   32'(d_busy),  32'd1);
    check("t4_cnt0",   32'(d_cnt),   32'd0);
    model = misr32(32'hFFFF_FFFF, 32'hCAFE_F00D);
    d_beat(32'hCAFE_F00D);
    check("t4_sig1",   d_sig,        model);
    check("t4_cnt1",   32'(d_cnt),   32'd1);

    // ---- test 5: start pulse in RUN after 3 beats is ignored ----
    model = misr32(model, 32'h0000_0001); d_beat(32'h0000_0001);
    model = misr32(model, 32'h8000_0000); d_beat(32'h8000_0000);
    check("t5_cnt3",   32'(d_cnt),   32'd3);
    d_start = 1'b1; tick(); d_start = 1'b0;
    check("t5_busy",   32'(d_busy),  32'd1);
    check("t5_cnt_st", 32'(d_cnt),   32'd3);
    check("t5_sig_st", d_sig,        model);
    model = misr32(model, 32'h5A5A_A5A5); d_beat(32'h5A5A_A5A5);
    check("t5_cnt4",   32'(d_cnt),   32'd4);
    check("t5_sig4",   d_sig,        model);

`ifdef BIST_TIMEOUT_EN
    // ---- test 6: 3 beats then silence -> timeout 8 cycles later ----
    d_rst = 1'b0; tick(); d_rst = 1'b1;
    d_start = 1'b1; tick(); d_start = 1'b0;
    model = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      model = misr32(model, 32'h0F0F_0000 + 32'(i));
      d_beat(32'h0F0F_0000 + 32'(i));
    end
    for (int i = 0; i < 7; i++) tick();
    check("t6_early",  32'(d_done),  32'd0);
    tick();
    check("t6_done",   32'(d_done),  32'd1);
    check("t6_pass",   32'(d_pass),  32'd0);
    check("t6_tmo",    32'(d_tmo),   32'd1);
    check("t6_cnt",    32'(d_cnt),   32'd3);
    check("t6_sig",    d_sig,        model);
    check("t6_busy",   32'(d_busy),  32'd0);
    d_start = 1'b1; tick(); d_start = 1'b0;
    check("t6_tclr",   32'(d_tmo),   32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bist_resp_checker
